// File: rtl/ccff_stream_loader_if.sv
// Handshake and chain-side signals between a bitstream source and the
// configuration-chain loader.
interface ccff_stream_loader_if #(
    parameter int WORD_W = 8,
    parameter int CNT_W  = 16
);
    logic              start;
    logic              verify;
    logic [WORD_W-1:0] word_in;
    logic              word_valid;
    logic              word_ready;
    logic              ccff_head;
    logic              ccff_tail;
    logic              shift_en;
    logic              busy;
    logic              done;
    logic [CNT_W-1:0]  mismatch_cnt;

    modport master (
        output start, verify, word_in, word_valid, ccff_tail,
        input  word_ready, ccff_head, shift_en, busy, done, mismatch_cnt
    );

    modport slave (
        input  start, verify, word_in, word_valid, ccff_tail,
        output word_ready, ccff_head, shift_en, busy, done, mismatch_cnt
    );
endinterface

// File: rtl/ccff_stream_loader.sv
// Serialises bitstream words onto a configuration chain (load pass), or rotates
// the chain through itself while comparing against a re-streamed copy (verify pass).
module ccff_stream_loader #(
    parameter int WORD_W    = 8,
    parameter int CHAIN_LEN = 16,
    parameter int CNT_W     = 16
) (
    input  logic                 prog_clk,
    input  logic                 prog_reset,
    ccff_stream_loader_if.slave  bus
);
    localparam int POS_W = (WORD_W > 1) ? $clog2(WORD_W) : 1;

    typedef enum logic [1:0] {IDLE, FETCH, SHIFT, FINISH} state_t;

    state_t            state, state_nxt;
    logic              mode;
    logic [WORD_W-1:0] shreg;
    logic [CNT_W-1:0]  bitcnt;
    logic [CNT_W-1:0]  mm_cnt;
    logic [POS_W-1:0]  bitpos;
    logic              last_bit;
    logic              word_end;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    assign last_bit = (bitcnt == CNT_W'(CHAIN_LEN - 1));
    assign word_end = (bitpos == POS_W'(WORD_W - 1));

    always_ff @(posedge prog_clk) begin
        if (prog_reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (bus.start) state_nxt = FETCH;
            FETCH:   if (bus.word_valid) state_nxt = SHIFT;
            SHIFT: begin
                if (last_bit) begin
                    state_nxt = FINISH;
                end else if (word_end) begin
                    state_nxt = FETCH;
                end
            end
            FINISH:  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge prog_clk) begin
        if (prog_reset) begin
            mode   <= 1'b0;
            shreg  <= '0;
            bitcnt <= '0;
            bitpos <= '0;
            mm_cnt <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        mode   <= bus.verify;
                        bitcnt <= '0;
                        if (bus.verify) mm_cnt <= '0;
                    end
                end
                FETCH: begin
                    if (bus.word_valid) begin
                        shreg  <= bus.word_in;
                        bitpos <= '0;
                    end
                end
                SHIFT: begin
                    shreg  <= shreg >> 1;
                    bitcnt <= bitcnt + 1'b1;
                    bitpos <= bitpos + 1'b1;
                    if (mode && (bus.ccff_tail != shreg[0])) mm_cnt <= sat_inc(mm_cnt);
                end
                default: ;
            endcase
        end
    end

    // Outputs decode from state only, so word_valid never reaches shift_en;
    // reset gates them so an abandoned pass stops the chain immediately.
    always_comb begin
        bus.word_ready   = 1'b0;
        bus.shift_en     = 1'b0;
        bus.busy         = 1'b0;
        bus.done         = 1'b0;
        bus.ccff_head    = 1'b0;
        bus.mismatch_cnt = '0;
        if (!prog_reset) begin
            bus.word_ready   = (state == FETCH);
            bus.shift_en     = (state == SHIFT);
            bus.busy         = (state != IDLE);
            bus.done         = (state == FINISH);
            bus.mismatch_cnt = mm_cnt;
            if (state == SHIFT) bus.ccff_head = mode ? bus.ccff_tail : shreg[0];
        end
    end
endmodule

// File: tb/tb_ccff_stream_loader.sv
// Bench for ccff_stream_loader: a 16-flop and a 12-flop chain instance driven in turn,
// checked against bitstream images computed from the word sequence.
module tb_ccff_stream_loader;
    localparam int W  = 8;
    localparam int LA = 16;
    localparam int LB = 12;
    localparam int CW = 16;

    logic prog_clk = 1'b0;
    logic prog_reset;
    always #5 prog_clk = ~prog_clk;

    ccff_stream_loader_if #(.WORD_W(W), .CNT_W(CW)) ifa ();
    ccff_stream_loader_if #(.WORD_W(W), .CNT_W(CW)) ifb ();

    ccff_stream_loader #(.WORD_W(W), .CHAIN_LEN(LA), .CNT_W(CW)) dut_a (
        .prog_clk(prog_clk), .prog_reset(prog_reset), .bus(ifa.slave));
    ccff_stream_loader #(.WORD_W(W), .CHAIN_LEN(LB), .CNT_W(CW)) dut_b (
        .prog_clk(prog_clk), .prog_reset(prog_reset), .bus(ifb.slave));

    logic          sel, start, verify, word_valid;
    logic [W-1:0]  word_in;
    logic [LA-1:0] chain_a;
    logic [LB-1:0] chain_b;

    assign ifa.start      = start & ~sel;
    assign ifa.verify     = verify;
    assign ifa.word_in    = word_in;
    assign ifa.word_valid = word_valid & ~sel;
    assign ifa.ccff_tail  = chain_a[0];
    assign ifb.start      = start & sel;
    assign ifb.verify     = verify;
    assign ifb.word_in    = word_in;
    assign ifb.word_valid = word_valid & sel;
    assign ifb.ccff_tail  = chain_b[0];

    // Downstream chains: bit 0 sits next to ccff_tail
    always @(posedge prog_clk) if (ifa.shift_en) chain_a <= {ifa.ccff_head, chain_a[LA-1:1]};
    always @(posedge prog_clk) if (ifb.shift_en) chain_b <= {ifb.ccff_head, chain_b[LB-1:1]};

    wire          m_shift = sel ? ifb.shift_en   : ifa.shift_en;
    wire          m_head  = sel ? ifb.ccff_head  : ifa.ccff_head;
    wire          m_tail  = sel ? ifb.ccff_tail  : ifa.ccff_tail;
    wire          m_ready = sel ? ifb.word_ready : ifa.word_ready;
    wire          m_done  = sel ? ifb.done       : ifa.done;
    wire          m_busy  = sel ? ifb.busy       : ifa.busy;
    wire [CW-1:0] m_mm    = sel ? ifb.mismatch_cnt : ifa.mismatch_cnt;

    int tests = 0;
    int fails = 0;

    int            r_shifts, r_accepts, r_ready, r_done_cyc, r_dones, r_eq_viol;
    logic [LA-1:0] r_heads;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge prog_clk);
        #1;
    endtask

    // Stream bit k is bit (k mod W) of word k/W; after a full pass it sits in chain flop k.
    function automatic logic [LA-1:0] stream_bits(input logic [W-1:0] w0, w1, w2, input int len);
        logic [3*W-1:0] cat;
        logic [LA-1:0]  r;
        cat = {w2, w1, w0};
        r   = '0;
        for (int k = 0; k < len; k++) r[k] = cat[k];
        return r;
    endfunction

    task automatic run_pass(input bit s, input bit vm, input logic [W-1:0] w0, w1, w2,
                            input int nw, input int gap, input int busy_start);
        int c, wi, gapleft;
        sel = s; verify = vm; start = 1'b1; word_valid = 1'b0;
        tick();
        start = 1'b0;
        c = 1; wi = 0; gapleft = gap;
        r_shifts = 0; r_accepts = 0; r_ready = 0; r_done_cyc = -1; r_dones = 0; r_eq_viol = 0;
        r_heads = '0;
        while (c < 200) begin
            start = (c == busy_start);
            if (wi == 1 && m_ready && gapleft > 0) begin
                word_valid = 1'b0;
                gapleft--;
            end else begin
                word_valid = (wi < nw);
            end
            word_in = (wi == 0) ? w0 : (wi == 1) ? w1 : w2;
            if (m_ready) r_ready++;
            if (m_ready && word_valid) begin
                r_accepts++;
                wi++;
            end
            if (m_shift) begin
                if (r_shifts < LA) r_heads[r_shifts] = m_head;
                r_shifts++;
                if (vm && (m_head !== m_tail)) r_eq_viol++;
            end
            if (m_done) begin
                r_dones++;
                r_done_cyc = c;
            end
            tick();
            c++;
            if (r_done_cyc >= 0) break;
        end
        start = 1'b0;
    endtask

    initial begin
        logic [W-1:0]  r0, r1, b0, b1, b2, v0, v1;
        logic [LA-1:0] img_a, exp_img;
        logic [CW-1:0] exp_mm_a;
        int            cnt, bcnt;

        sel = 1'b0; start = 1'b0; verify = 1'b0; word_valid = 1'b0; word_in = '0;
        chain_a = '0; chain_b = '0;
        prog_reset = 1'b1;
        repeat (3) tick();
        check("rst_busy_a",  ifa.busy, 0);
        check("rst_ready_a", ifa.word_ready, 0);
        check("rst_shift_a", ifa.shift_en, 0);
        check("rst_done_a",  ifa.done, 0);
        check("rst_head_a",  ifa.ccff_head, 0);
        check("rst_mm_a",    ifa.mismatch_cnt, 0);
        check("rst_busy_b",  ifb.busy, 0);
        prog_reset = 1'b0;
        tick();

        // Reset abandoning a pass mid-word
        start = 1'b1; verify = 1'b0; word_valid = 1'b1; word_in = 8'hFF;
        tick();
        start = 1'b0;
        repeat (4) tick();
        check("midpass_shifting", ifa.shift_en, 1);
        prog_reset = 1'b1;
        tick();
        check("abort_shift", ifa.shift_en, 0);
        check("abort_busy",  ifa.busy, 0);
        check("abort_ready", ifa.word_ready, 0);
        check("abort_done",  ifa.done, 0);
        prog_reset = 1'b0; word_valid = 1'b0;
        cnt = 0; bcnt = 0;
        for (int i = 0; i < 30; i++) begin
            if (ifa.done) cnt++;
            if (ifa.busy) bcnt++;
            tick();
        end
        check("abort_no_done", cnt, 0);
        check("abort_idle",    bcnt, 0);
        exp_mm_a = '0;

        // Clean load of 0xA5, 0x3C
        img_a = stream_bits(8'hA5, 8'h3C, 8'h00, LA);
        run_pass(0, 0, 8'hA5, 8'h3C, 8'h00, 2, 0, -1);
        check("load_shifts",  r_shifts, LA);
        check("load_accepts", r_accepts, 2);
        check("load_ready",   r_ready, 2);
        check("load_donecyc", r_done_cyc, 19);
        check("load_dones",   r_dones, 1);
        check("load_heads",   r_heads, 16'h3CA5);
        check("load_chain",   chain_a, 16'h3CA5);
        check("load_idle",    ifa.busy, 0);

        // Starved source: five empty fetch cycles
        chain_a = '0;
        run_pass(0, 0, 8'hA5, 8'h3C, 8'h00, 2, 5, -1);
        check("starve_shifts",  r_shifts, LA);
        check("starve_ready",   r_ready, 7);
        check("starve_donecyc", r_done_cyc, 24);
        check("starve_chain",   chain_a, img_a);

        // Verify with the matching image, then with one flipped bit
        run_pass(0, 1, 8'hA5, 8'h3C, 8'h00, 2, 0, -1);
        check("vmatch_mm",    ifa.mismatch_cnt, 0);
        check("vmatch_dones", r_dones, 1);
        check("vmatch_loop",  r_eq_viol, 0);
        check("vmatch_chain", chain_a, img_a);
        exp_mm_a = CW'($countones(img_a ^ stream_bits(8'hA4, 8'h3C, 8'h00, LA)));
        run_pass(0, 1, 8'hA4, 8'h3C, 8'h00, 2, 0, -1);
        check("vmis_mm",    ifa.mismatch_cnt, exp_mm_a);
        check("vmis_chain", chain_a, img_a);

        // Random load keeps the previous verify count
        r0 = W'($urandom); r1 = W'($urandom);
        img_a = stream_bits(r0, r1, 8'h00, LA);
        run_pass(0, 0, r0, r1, 8'h00, 2, 0, -1);
        check("rload_chain", chain_a, img_a);
        check("rload_mm_kept", ifa.mismatch_cnt, exp_mm_a);

        for (int t = 0; t < 4; t++) begin
            v0 = r0 ^ (W'($urandom) & W'($urandom));
            v1 = r1 ^ (W'($urandom) & W'($urandom));
            exp_mm_a = CW'($countones(img_a ^ stream_bits(v0, v1, 8'h00, LA)));
            run_pass(0, 1, v0, v1, 8'h00, 2, 0, -1);
            check("rver_mm",    ifa.mismatch_cnt, exp_mm_a);
            check("rver_chain", chain_a, img_a);
            check("rver_loop",  r_eq_viol, 0);
        end

        // 12-flop chain: partial final word, pending third word, start while busy
        b0 = W'($urandom); b1 = W'($urandom); b2 = W'($urandom);
        exp_img = stream_bits(b0, b1, 8'h00, LB);
        run_pass(1, 0, b0, b1, b2, 3, 0, 5);
        check("part_shifts",  r_shifts, LB);
        check("part_accepts", r_accepts, 2);
        check("part_donecyc", r_done_cyc, 15);
        check("part_heads",   r_heads, exp_img);
        check("part_chain",   chain_b, exp_img[LB-1:0]);
        cnt = 0; bcnt = 0;
        for (int i = 0; i < 6; i++) begin
            if (ifb.word_ready) cnt++;
            if (ifb.busy) bcnt++;
            tick();
        end
        check("part_pending_ready", cnt, 0);
        check("part_no_restart",    bcnt, 0);
        word_valid = 1'b0;

        v1 = b1 ^ 8'hF1;
        run_pass(1, 1, b0, v1, 8'h00, 2, 0, -1);
        check("part_vmm",   ifb.mismatch_cnt,
              CW'($countones(exp_img ^ stream_bits(b0, v1, 8'h00, LB))));
        check("part_vchain", chain_b, exp_img[LB-1:0]);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule
